// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's MEM stage and the data-memory responder.
// Latency: none (wires only); timing is set by the responder behind the slave modport.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
//
// Signals:
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          zero-extend loads when 1
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load result (0 for stores and faults)
//   rsp_error             access fault
interface dmem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory slave answering byte/half/word loads and stores from the MEM stage.
// Latency: request accepted at edge N, response valid after edge N+1+LATENCY.
// Backpressure: one request outstanding; req_ready drops until the response is taken with rsp_ready.
//
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous active-low reset
//   bus     dmem_responder_if slave modport (request and response channels)
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        LAT4      = 4'(LATENCY);
    localparam logic [ADDR_W-3:0] IDX_LIMIT = (ADDR_W-2)'(DEPTH);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 0..15");
    end
    if (ADDR_W < MIDX_W + 2) begin : g_bad_addr_w
        $error("dmem_responder: ADDR_W too narrow for DEPTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] data_memory [DEPTH];

    logic              ready_q;
    logic [3:0]        cnt;
    logic              cap_write;
    logic [1:0]        cap_size;
    logic              cap_unsigned;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [31:0]       rdata_q;
    logic              error_q;

    logic              accept;
    logic              access;
    logic              acc_err;
    logic              mem_we;
    logic [MIDX_W-1:0] mem_idx;
    logic [31:0]       cur_word;
    logic [31:0]       st_word;
    logic [31:0]       ld_val;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    assign accept = (state == IDLE) && ready_q && bus.req_valid;
    // The access happens on the edge that leaves WAIT with an expired counter,
    // so a request always spends LATENCY+1 edges in WAIT.
    assign access = (state == WAIT) && (cnt == 4'd0);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = WAIT;
            WAIT:    if (access)        state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Fault detection on the captured request
    always_comb begin
        acc_err = 1'b0;
        case (cap_size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = cap_addr[0];
            2'b10:   acc_err = |cap_addr[1:0];
            default: acc_err = 1'b1;
        endcase
        if (cap_addr[ADDR_W-1:2] >= IDX_LIMIT) begin
            acc_err = 1'b1;
        end
    end

    assign mem_idx  = cap_addr[2 +: MIDX_W];
    assign cur_word = data_memory[mem_idx];

    // Little-endian lane extraction and load extension
    always_comb begin
        ld_byte = cur_word[{cap_addr[1:0], 3'b000} +: 8];
        ld_half = cur_word[{cap_addr[1], 4'b0000} +: 16];
        case (cap_size)
            2'b00:   ld_val = {{24{~cap_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~cap_unsigned & ld_half[15]}}, ld_half};
            default: ld_val = cur_word;
        endcase
    end

    // Store merge: only the addressed lane(s) change
    always_comb begin
        st_word = cur_word;
        case (cap_size)
            2'b00:   st_word[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
            2'b01:   st_word[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
            2'b10:   st_word = cap_wdata;
            default: st_word = cur_word;
        endcase
    end

    // state is forced to IDLE asynchronously by reset, which kills a pending write.
    assign mem_we = access && cap_write && !acc_err;

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            data_memory[mem_idx] <= st_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            cnt          <= 4'd0;
            cap_write    <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= 32'd0;
            rdata_q      <= 32'd0;
            error_q      <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Registered ready: high exactly when the FSM will sit in IDLE.
            ready_q <= (state_nxt == IDLE);
            if (accept) begin
                cap_write    <= bus.req_write;
                cap_size     <= bus.req_size;
                cap_unsigned <= bus.req_unsigned;
                cap_addr     <= bus.req_addr;
                cap_wdata    <= bus.req_wdata;
                cnt          <= LAT4;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rdata_q <= (cap_write || acc_err) ? 32'd0 : ld_val;
                error_q <= acc_err;
            end else if ((state == RESP) && bus.rsp_ready) begin
                rdata_q <= 32'd0;
                error_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;

endmodule
